program_loader: RTL and testbench

Boot-time writer for the program memory's fill port. It accepts a big-endian byte stream over a valid/ready handshake, assembles 32-bit instructions, and issues one-cycle write pulses with word-aligned addresses. While loading, it holds the CPU in reset via cpu_hold and releases it when the image is complete.

---
 rtl/program_loader_pkg.sv | 23 ++
 rtl/loader_word_assembler.sv | 36 +++
 rtl/program_loader.sv | 147 ++++++++++++++
 tb/tb_program_loader.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/program_loader_pkg.sv
// Shared definitions for the boot-time program loader.
package program_loader_pkg;

    localparam int HDR_W  = 16;
    localparam int WORD_W = 32;
    localparam int BYTE_W = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR_HI,
        S_HDR_LO,
        S_DATA,
        S_WRITE,
        S_DONE,
        S_ERR
    } state_t;

    // Number of whole words that fit between BASE_ADDR and the top of memory.
    function automatic logic [31:0] max_words(input int mem_bytes, input int base_addr);
        return 32'((mem_bytes - base_addr) / 4);
    endfunction

endpackage

// File: rtl/loader_word_assembler.sv
// Collects four stream bytes, MSB first, into one 32-bit instruction word.
module loader_word_assembler
    import program_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              shift_en,
    input  logic [BYTE_W-1:0] in_byte,
    output logic [WORD_W-1:0] word,
    output logic              word_full,
    output logic              last_byte
);

    logic [2:0]        r_cnt;
    logic [WORD_W-1:0] r_word;

    // Byte counter and shift register; clear only rewinds the counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_word <= '0;
        end else if (clear) begin
            r_cnt  <= '0;
        end else if (shift_en && !word_full) begin
            r_word <= {r_word[WORD_W-BYTE_W-1:0], in_byte};
            r_cnt  <= r_cnt + 3'd1;
        end
    end

    assign word      = r_word;
    assign word_full = (r_cnt == 3'd4);
    // Next shifted byte completes the word; lets the FSM reach WRITE without a bubble.
    assign last_byte = (r_cnt == 3'd3);

endmodule

// File: rtl/program_loader.sv
// Streams a length-prefixed big-endian image into program memory and holds
// the CPU in reset until the image is complete.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int MEM_BYTES = 4096,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [BYTE_W-1:0] in_byte,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              mem_write,
    output logic [31:0]       mem_address,
    output logic [WORD_W-1:0] mem_data,
    output logic              cpu_hold,
    output logic              done,
    output logic              error
);

    localparam logic [31:0] MAX_WORDS = max_words(MEM_BYTES, BASE_ADDR);

    state_t            r_state, w_next;
    logic [HDR_W-1:0]  r_n;
    logic [HDR_W-1:0]  r_word_idx;
    logic [31:0]       r_addr_hold;
    logic [WORD_W-1:0] r_data_hold;

    logic              w_clear, w_shift, w_start_ok;
    logic [HDR_W-1:0]  w_hdr_n;
    logic [31:0]       w_addr;
    logic [WORD_W-1:0] w_word;
    logic              w_word_full, w_last_byte;

    loader_word_assembler u_asm (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (w_clear),
        .shift_en  (w_shift),
        .in_byte   (in_byte),
        .word      (w_word),
        .word_full (w_word_full),
        .last_byte (w_last_byte)
    );

    assign w_hdr_n    = {r_n[HDR_W-1:BYTE_W], in_byte};
    assign w_addr     = 32'(BASE_ADDR) + {14'd0, r_word_idx, 2'b00};
    assign w_start_ok = start && (r_state == S_IDLE || r_state == S_DONE || r_state == S_ERR);

    // While strobing, present the live word/address; otherwise hold the last write.
    assign mem_data    = mem_write ? w_word : r_data_hold;
    assign mem_address = mem_write ? w_addr : r_addr_hold;

    // State register plus header, word index and output hold registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_n         <= '0;
            r_word_idx  <= '0;
            r_addr_hold <= '0;
            r_data_hold <= '0;
        end else begin
            r_state <= w_next;
            if (w_start_ok)
                r_word_idx <= '0;
            if (r_state == S_HDR_HI && in_valid)
                r_n[HDR_W-1:BYTE_W] <= in_byte;
            if (r_state == S_HDR_LO && in_valid)
                r_n[BYTE_W-1:0] <= in_byte;
            if (mem_write) begin
                r_word_idx  <= r_word_idx + 16'd1;
                r_addr_hold <= w_addr;
                r_data_hold <= w_word;
            end
        end
    end

    // Next-state and Moore outputs; in_valid alone qualifies acceptance in
    // the states where in_ready is 1.
    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        mem_write = 1'b0;
        done      = 1'b0;
        error     = 1'b0;
        cpu_hold  = 1'b1;
        w_clear   = 1'b0;
        w_shift   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next  = S_HDR_HI;
                    w_clear = 1'b1;
                end
            end
            S_HDR_HI: begin
                in_ready = 1'b1;
                if (in_valid)
                    w_next = S_HDR_LO;
            end
            S_HDR_LO: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (w_hdr_n == '0)
                        w_next = S_DONE;
                    else if ({16'd0, w_hdr_n} > MAX_WORDS)
                        w_next = S_ERR;
                    else
                        w_next = S_DATA;
                end
            end
            S_DATA: begin
                in_ready = 1'b1;
                w_shift  = in_valid;
                if (in_valid && w_last_byte)
                    w_next = S_WRITE;
            end
            S_WRITE: begin
                mem_write = w_word_full;
                w_clear   = 1'b1;
                if (r_word_idx + 16'd1 == r_n)
                    w_next = S_DONE;
                else
                    w_next = S_DATA;
            end
            S_DONE: begin
                done     = 1'b1;
                cpu_hold = 1'b0;
                if (start) begin
                    w_next  = S_HDR_HI;
                    w_clear = 1'b1;
                end
            end
            S_ERR: begin
                error = 1'b1;
                if (start) begin
                    w_next  = S_HDR_HI;
                    w_clear = 1'b1;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: table of whole-image loads plus
// hand-written timing, gap, reset and capacity sequences.
module tb_program_loader;

    logic        clk = 1'b0;
    logic        rst_n, start, in_valid;
    logic [7:0]  in_byte;
    logic        in_ready, mem_write, cpu_hold, done, error;
    logic [31:0] mem_address, mem_data;

    always #5 clk = ~clk;

    program_loader #(.MEM_BYTES(4096), .BASE_ADDR(0)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .in_byte     (in_byte),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .mem_write   (mem_write),
        .mem_address (mem_address),
        .mem_data    (mem_data),
        .cpu_hold    (cpu_hold),
        .done        (done),
        .error       (error)
    );

    int checks = 0;
    int failures = 0;

    logic [31:0] wq_a[$];
    logic [31:0] wq_d[$];
    logic [31:0] pmem [0:1023];

    // Capture every write pulse into a queue and a program memory model.
    always @(negedge clk) begin
        if (mem_write) begin
            wq_a.push_back(mem_address);
            wq_d.push_back(mem_data);
            pmem[mem_address[11:2]] = mem_data;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    typedef struct {
        int              nb;
        logic [111:0]    s;
        int              nw;
        logic [2:0][31:0] d;
        logic            exp_done;
        logic            exp_err;
    } vec_t;

    vec_t vt[4];

    function automatic logic [111:0] lj(input logic [111:0] v, input int nb);
        return v << (112 - 8 * nb);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit ok;
        ok = 1'b0;
        in_byte  = b;
        in_valid = 1'b1;
        for (int k = 0; k < 20 && !ok; k++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                ok = 1'b1;
            end
        end
        in_valid = 1'b0;
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL send_byte timeout actual=no_ready required=ready byte=%h", b);
        end
    endtask

    task automatic wait_end();
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 40 && !ok; k++) begin
            @(negedge clk);
            if (done || error) ok = 1'b1;
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL wait_end timeout actual=busy required=done_or_error");
        end
    endtask

    task automatic clear_q();
        wq_a.delete();
        wq_d.delete();
    endtask

    task automatic run_vec(input int k);
        clear_q();
        pulse_start();
        for (int i = 0; i < vt[k].nb; i++)
            send_byte(vt[k].s[111 - 8 * i -: 8]);
        wait_end();
        chk($sformatf("v%0d done", k), {31'd0, done}, {31'd0, vt[k].exp_done});
        chk($sformatf("v%0d error", k), {31'd0, error}, {31'd0, vt[k].exp_err});
        chk($sformatf("v%0d cpu_hold", k), {31'd0, cpu_hold}, {31'd0, ~vt[k].exp_done});
        chk($sformatf("v%0d nwrites", k), wq_d.size(), vt[k].nw);
        for (int i = 0; i < vt[k].nw; i++) begin
            if (i < wq_d.size()) begin
                chk($sformatf("v%0d addr%0d", k, i), wq_a[i], 32'(4 * i));
                chk($sformatf("v%0d data%0d", k, i), wq_d[i], vt[k].d[i]);
            end
        end
    endtask

    logic       pat [7];
    logic [7:0] gb  [4];

    initial begin
        // Table: whole-image loads with hand-computed results.
        vt[0] = '{nb: 2, s: lj(112'h0000, 2), nw: 0, d: '0, exp_done: 1'b1, exp_err: 1'b0};
        vt[1] = '{nb: 2, s: lj(112'h0401, 2), nw: 0, d: '0, exp_done: 1'b0, exp_err: 1'b1};
        vt[2] = '{nb: 6, s: lj(112'h0001_DEAD_BEEF, 6), nw: 1, d: '0, exp_done: 1'b1, exp_err: 1'b0};
        vt[2].d[0] = 32'hDEADBEEF;
        vt[3] = '{nb: 14, s: 112'h0003_1122_3344_5566_7788_99AA_BBCC, nw: 3, d: '0,
                  exp_done: 1'b1, exp_err: 1'b0};
        vt[3].d[0] = 32'h11223344;
        vt[3].d[1] = 32'h55667788;
        vt[3].d[2] = 32'h99AABBCC;

        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_byte = 8'h00;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state.
        @(negedge clk);
        chk("rst in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst mem_write", {31'd0, mem_write}, 32'd0);
        chk("rst mem_address", mem_address, 32'd0);
        chk("rst mem_data", mem_data, 32'd0);
        chk("rst done", {31'd0, done}, 32'd0);
        chk("rst error", {31'd0, error}, 32'd0);
        chk("rst cpu_hold", {31'd0, cpu_hold}, 32'd1);

        // Two-word image with exact pulse and done timing.
        clear_q();
        pulse_start();
        send_byte(8'h00); send_byte(8'h02);
        send_byte(8'h20); send_byte(8'h08); send_byte(8'h00); send_byte(8'h05);
        @(negedge clk);
        chk("t1 w0 strobe", {31'd0, mem_write}, 32'd1);
        chk("t1 w0 addr", mem_address, 32'h0);
        chk("t1 w0 data", mem_data, 32'h20080005);
        send_byte(8'hAC); send_byte(8'h09); send_byte(8'h00); send_byte(8'h00);
        @(negedge clk);
        chk("t1 w1 strobe", {31'd0, mem_write}, 32'd1);
        chk("t1 w1 addr", mem_address, 32'h4);
        chk("t1 w1 data", mem_data, 32'hAC090000);
        chk("t1 done early", {31'd0, done}, 32'd0);
        @(negedge clk);
        chk("t1 done", {31'd0, done}, 32'd1);
        chk("t1 cpu_hold", {31'd0, cpu_hold}, 32'd0);
        chk("t1 strobe off", {31'd0, mem_write}, 32'd0);
        chk("t1 addr hold", mem_address, 32'h4);
        chk("t1 data hold", mem_data, 32'hAC090000);
        chk("t1 nwrites", wq_d.size(), 2);
        chk("t1 pmem pc4", pmem[1], 32'hAC090000);

        // Empty image: DONE in the cycle after the second header byte.
        clear_q();
        pulse_start();
        send_byte(8'h00); send_byte(8'h00);
        @(negedge clk);
        chk("t2 done", {31'd0, done}, 32'd1);
        chk("t2 nwrites", wq_d.size(), 0);

        // Oversized header, then bytes offered while not ready are ignored.
        clear_q();
        pulse_start();
        send_byte(8'h04); send_byte(8'h01);
        @(negedge clk);
        chk("t3 error", {31'd0, error}, 32'd1);
        chk("t3 cpu_hold", {31'd0, cpu_hold}, 32'd1);
        chk("t3 in_ready", {31'd0, in_ready}, 32'd0);
        in_byte = 8'h55; in_valid = 1'b1;
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        chk("t3 error held", {31'd0, error}, 32'd1);
        chk("t3 nwrites", wq_d.size(), 0);

        // Table-driven loads (vector 2 also checks recovery from ERR).
        for (int k = 0; k < 4; k++)
            run_vec(k);

        // Gapped in_valid during one data word.
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        gb  = '{8'h12, 8'h34, 8'h56, 8'h78};
        clear_q();
        pulse_start();
        send_byte(8'h00); send_byte(8'h01);
        begin
            int idx;
            idx = 0;
            for (int c = 0; c < 7; c++) begin
                in_valid = pat[c];
                in_byte  = pat[c] ? gb[idx] : 8'hEE;
                @(posedge clk);
                #1;
                if (pat[c]) idx++;
            end
        end
        in_valid = 1'b0;
        wait_end();
        chk("t4 done", {31'd0, done}, 32'd1);
        chk("t4 nwrites", wq_d.size(), 1);
        if (wq_d.size() > 0) chk("t4 data", wq_d[0], 32'h12345678);

        // Reset after two of four data bytes.
        clear_q();
        pulse_start();
        send_byte(8'h00); send_byte(8'h01); send_byte(8'h9A); send_byte(8'hBC);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("t5 mem_write", {31'd0, mem_write}, 32'd0);
        chk("t5 in_ready", {31'd0, in_ready}, 32'd0);
        chk("t5 done", {31'd0, done}, 32'd0);
        chk("t5 error", {31'd0, error}, 32'd0);
        chk("t5 cpu_hold", {31'd0, cpu_hold}, 32'd1);
        chk("t5 mem_address", mem_address, 32'd0);
        chk("t5 mem_data", mem_data, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("t5 nwrites", wq_d.size(), 0);
        run_vec(2);

        // start during DATA is ignored.
        clear_q();
        pulse_start();
        send_byte(8'h00); send_byte(8'h02); send_byte(8'hA1); send_byte(8'hA2);
        pulse_start();
        send_byte(8'hA3); send_byte(8'hA4);
        send_byte(8'hB1); send_byte(8'hB2); send_byte(8'hB3); send_byte(8'hB4);
        wait_end();
        chk("t6 done", {31'd0, done}, 32'd1);
        chk("t6 nwrites", wq_d.size(), 2);
        if (wq_d.size() == 2) begin
            chk("t6 addr0", wq_a[0], 32'h0);
            chk("t6 data0", wq_d[0], 32'hA1A2A3A4);
            chk("t6 addr1", wq_a[1], 32'h4);
            chk("t6 data1", wq_d[1], 32'hB1B2B3B4);
        end

        // Exactly-full image: 1024 words is accepted.
        clear_q();
        pulse_start();
        send_byte(8'h04); send_byte(8'h00);
        for (int i = 0; i < 4096; i++)
            send_byte(i[7:0]);
        wait_end();
        chk("t7 done", {31'd0, done}, 32'd1);
        chk("t7 error", {31'd0, error}, 32'd0);
        chk("t7 nwrites", wq_d.size(), 1024);
        if (wq_d.size() == 1024) begin
            chk("t7 last addr", wq_a[1023], 32'hFFC);
            chk("t7 last data", wq_d[1023], 32'hFCFDFEFF);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
